// File: rtl/fma16_arb_if.sv
// Request/response bundle between two requesters and the shared fma16 arbiter.
interface fma16_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_x0, req_y0, req_z0;
    logic [15:0] req_x1, req_y1, req_z1;
    logic [5:0]  req_ctrl0, req_ctrl1;
    logic [1:0]  req_acc;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;

    modport master (
        output req_valid, req_x0, req_y0, req_z0, req_x1, req_y1, req_z1,
               req_ctrl0, req_ctrl1, req_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_x0, req_y0, req_z0, req_x1, req_y1, req_z1,
               req_ctrl0, req_ctrl1, req_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/fma16_arb.sv
// Half-precision fused multiply-add core shared by two requesters through a
// round-robin arbiter with per-port accumulators and sticky exception flags.
module fma16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    // Exact fixed-point sum: bit k weighs 2^(k-48), wide enough for any product plus addend.
    localparam int unsigned W = 84;

    logic [15:0]  yv, zv;
    logic [4:0]   bx, by, bz;
    logic [10:0]  mx, my, mz;
    logic         xnan, ynan, znan, snan;
    logic         xinf, yinf, zinf, xzero, yzero;
    logic         ps, zs, rsign, zsign;
    logic [21:0]  mp;
    logic [6:0]   pshift, zshift, lead, lsbpos;
    logic [W-1:0] pv, zal, mag;
    logic [10:0]  mant;
    logic         rbit, sbit, inc, inexact, ovf, tiny, to_inf;
    logic [5:0]   ebase;
    logic [16:0]  enc;

    assign yv = mul ? y : 16'h3C00;
    assign zv = add ? z : 16'h0000;

    assign bx = (x[14:10] == 5'd0)  ? 5'd1 : x[14:10];
    assign by = (yv[14:10] == 5'd0) ? 5'd1 : yv[14:10];
    assign bz = (zv[14:10] == 5'd0) ? 5'd1 : zv[14:10];
    assign mx = {|x[14:10], x[9:0]};
    assign my = {|yv[14:10], yv[9:0]};
    assign mz = {|zv[14:10], zv[9:0]};

    assign xnan  = (&x[14:10])  && (|x[9:0]);
    assign ynan  = (&yv[14:10]) && (|yv[9:0]);
    assign znan  = (&zv[14:10]) && (|zv[9:0]);
    assign snan  = (xnan && !x[9]) || (ynan && !yv[9]) || (znan && !zv[9]);
    assign xinf  = (&x[14:10])  && !(|x[9:0]);
    assign yinf  = (&yv[14:10]) && !(|yv[9:0]);
    assign zinf  = (&zv[14:10]) && !(|zv[9:0]);
    assign xzero = !(|x[14:0]);
    assign yzero = !(|yv[14:0]);

    always_comb begin
        result = '0;
        flags  = '0;
        ps     = x[15] ^ yv[15] ^ negp;
        zs     = zv[15] ^ negz;
        mp     = 22'(mx) * 22'(my);
        pshift = 7'(bx) + 7'(by) - 7'd2;
        zshift = 7'(bz) + 7'd23;
        pv     = W'(mp) << pshift;
        zal    = W'(mz) << zshift;

        if (ps == zs) begin
            mag   = pv + zal;
            rsign = ps;
        end else if (pv >= zal) begin
            mag   = pv - zal;
            rsign = ps;
        end else begin
            mag   = zal - pv;
            rsign = zs;
        end

        lead = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (mag[i]) lead = 7'(i);
        end

        // Result LSB weighs 2^-24 at minimum, which handles subnormals without a separate path.
        lsbpos = (lead >= 7'd34) ? lead - 7'd10 : 7'd24;
        mant   = 11'(mag >> lsbpos);
        rbit   = mag[lsbpos - 7'd1];
        sbit   = |(mag & ((W'(1) << (lsbpos - 7'd1)) - W'(1)));

        case (roundmode)
            2'b00:   inc = 1'b0;
            2'b01:   inc = rbit & (sbit | mant[0]);
            2'b10:   inc = (rbit | sbit) & rsign;
            default: inc = (rbit | sbit) & ~rsign;
        endcase

        // Biased (exp-1) plus hidden-bit significand lets a rounding carry bump the exponent.
        ebase   = (lead >= 7'd34) ? 6'(lead - 7'd34) : 6'd0;
        enc     = (17'(ebase) << 10) + 17'(mant) + 17'(inc);
        inexact = rbit | sbit;
        ovf     = enc >= 17'h07C00;
        tiny    = lead < 7'd34;
        to_inf  = (roundmode == 2'b01) || (roundmode == 2'b10 && rsign) ||
                  (roundmode == 2'b11 && !rsign);
        zsign   = (ps == zs) ? ps : (roundmode == 2'b10);

        if (xnan || ynan || znan) begin
            result = 16'h7E00;
            flags  = {snan, 3'b000};
        end else if ((xinf && yzero) || (yinf && xzero) ||
                     ((xinf || yinf) && zinf && (ps != zs))) begin
            result = 16'h7E00;
            flags  = 4'b1000;
        end else if (xinf || yinf) begin
            result = {ps, 15'h7C00};
        end else if (zinf) begin
            result = {zs, 15'h7C00};
        end else if (mag == '0) begin
            result = {zsign, 15'h0000};
        end else if (ovf) begin
            result = to_inf ? {rsign, 15'h7C00} : {rsign, 15'h7BFF};
            flags  = 4'b0101;
        end else begin
            result = {rsign, enc[14:0]};
            flags  = {2'b00, tiny & inexact, inexact};
        end
    end
endmodule

module fma16_arb #(
    parameter logic [15:0] ACC_INIT    = 16'h0000,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    fma16_arb_if.slave  bus,
    input  logic [1:0]  clr,
    output logic [3:0]  sticky0,
    output logic [3:0]  sticky1,
    output logic [15:0] acc0,
    output logic [15:0] acc1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_next;
    logic        prio, owner;
    logic [15:0] op_x, op_y, op_z;
    logic [5:0]  op_ctrl;
    logic [15:0] rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic [15:0] acc_q [2];
    logic [3:0]  sticky_q [2];
    logic [1:0]  grant, rsp_valid;
    logic        gnt_port, rsp_hs;
    logic [15:0] fma_result;
    logic [3:0]  fma_flags;

    fma16 core (
        .x         (op_x),
        .y         (op_y),
        .z         (op_z),
        .mul       (op_ctrl[3]),
        .add       (op_ctrl[2]),
        .negp      (op_ctrl[1]),
        .negz      (op_ctrl[0]),
        .roundmode (op_ctrl[5:4]),
        .result    (fma_result),
        .flags     (fma_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = '0;
        gnt_port   = 1'b0;
        rsp_valid  = '0;
        rsp_hs     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid[0] && (!bus.req_valid[1] || !prio)) begin
                    grant    = 2'b01;
                    gnt_port = 1'b0;
                end else if (bus.req_valid[1]) begin
                    grant    = 2'b10;
                    gnt_port = 1'b1;
                end
                if (grant != '0) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (bus.rsp_ready[owner]) begin
                    rsp_hs     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio         <= 1'b0;
            owner        <= 1'b0;
            op_x         <= '0;
            op_y         <= '0;
            op_z         <= '0;
            op_ctrl      <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            for (int unsigned p = 0; p < 2; p++) begin
                acc_q[p]    <= ACC_INIT;
                sticky_q[p] <= '0;
            end
        end else begin
            if (grant != '0) begin
                owner   <= gnt_port;
                op_x    <= gnt_port ? bus.req_x1 : bus.req_x0;
                op_y    <= gnt_port ? bus.req_y1 : bus.req_y0;
                op_z    <= bus.req_acc[gnt_port] ? acc_q[gnt_port]
                         : (gnt_port ? bus.req_z1 : bus.req_z0);
                op_ctrl <= gnt_port ? bus.req_ctrl1 : bus.req_ctrl0;
                if (ROUND_ROBIN) prio <= ~gnt_port;
            end
            if (state == EXEC) begin
                rsp_result_q <= fma_result;
                rsp_flags_q  <= fma_flags;
            end
            // A clear in the handshake cycle overrides the accumulate/flag update.
            for (int unsigned p = 0; p < 2; p++) begin
                if (clr[p]) begin
                    acc_q[p]    <= ACC_INIT;
                    sticky_q[p] <= '0;
                end else if (rsp_hs && owner == 1'(p)) begin
                    acc_q[p]    <= rsp_result_q;
                    sticky_q[p] <= sticky_q[p] | rsp_flags_q;
                end
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign acc0           = acc_q[0];
    assign acc1           = acc_q[1];
    assign sticky0        = sticky_q[0];
    assign sticky1        = sticky_q[1];
endmodule
